// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_univ
//  Purpose  : Parametrised universal shift register with eight modes (hold,
//             shift R/L, rotate R/L, parallel load, arithmetic shift right,
//             clear), a saturating shift counter and a completion pulse.
//  Revision : 1.0  initial release
// ============================================================================
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_SHR  = 3'b001;
    localparam logic [2:0] c_MODE_SHL  = 3'b010;
    localparam logic [2:0] c_MODE_ROR  = 3'b011;
    localparam logic [2:0] c_MODE_ROL  = 3'b100;
    localparam logic [2:0] c_MODE_LOAD = 3'b101;
    localparam logic [2:0] c_MODE_ASR  = 3'b110;
    localparam logic [2:0] c_MODE_CLR  = 3'b111;

    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_q_next;
    logic             w_shift;   // operation counts toward the shift counter
    logic             w_rearm;   // operation resets the shift counter

    // Next register value and operation class decoded from mode
    always_comb begin
        w_q_next = r_q;
        w_shift  = 1'b0;
        w_rearm  = 1'b0;
        case (mode)
            c_MODE_HOLD: begin
                w_q_next = r_q;
            end
            c_MODE_SHR: begin
                w_q_next = {sin_r, r_q[WIDTH-1:1]};
                w_shift  = 1'b1;
            end
            c_MODE_SHL: begin
                w_q_next = {r_q[WIDTH-2:0], sin_l};
                w_shift  = 1'b1;
            end
            c_MODE_ROR: begin
                w_q_next = {r_q[0], r_q[WIDTH-1:1]};
                w_shift  = 1'b1;
            end
            c_MODE_ROL: begin
                w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_shift  = 1'b1;
            end
            c_MODE_LOAD: begin
                w_q_next = D;
                w_rearm  = 1'b1;
            end
            c_MODE_ASR: begin
                // MSB replicated; sin_r deliberately unused here
                w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_shift  = 1'b1;
            end
            c_MODE_CLR: begin
                w_q_next = '0;
                w_rearm  = 1'b1;
            end
            default: begin
                w_q_next = r_q;
            end
        endcase
    end

    // Register, counter and done pulse; reset beats enable beats mode
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!en) begin
            r_done <= 1'b0;
        end else begin
            r_q <= w_q_next;
            if (w_rearm) begin
                r_cnt <= '0;
            end else if (w_shift && (r_cnt < c_CNT_MAX)) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            // Pulse only on the WIDTH-1 -> WIDTH transition, never at saturation
            r_done <= w_shift && (r_cnt == c_CNT_LAST);
        end
    end

    assign Q      = r_q;
    assign cnt    = r_cnt;
    assign done   = r_done;
    assign sout_r = r_q[0];
    assign sout_l = r_q[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_reg_univ
//  Purpose  : Self-checking bench for shift_reg_univ at WIDTH=4 and WIDTH=8,
//             sharing one control stream, against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_reg_univ;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic [7:0] d8 = 8'h00;

    logic [3:0] q4;
    logic [2:0] cnt4;
    logic       sr4, sl4, done4;
    logic [7:0] q8;
    logic [3:0] cnt8;
    logic       sr8, sl8, done8;

    int n_total = 0;
    int n_pass  = 0;
    bit mon_on  = 1'b0;

    // Model state: index 0 is the 4-bit instance, index 1 the 8-bit one
    int          mw [2] = '{4, 8};
    logic [31:0] mq [2];
    int          mc [2];
    bit          md [2];

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_r(sin_r),
        .sin_l(sin_l), .D(d8[3:0]), .Q(q4), .sout_r(sr4), .sout_l(sl4),
        .cnt(cnt4), .done(done4)
    );

    shift_reg_univ #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_r(sin_r),
        .sin_l(sin_l), .D(d8), .Q(q8), .sout_r(sr8), .sout_l(sl8),
        .cnt(cnt8), .done(done8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Register value after one enabled operation, from the mode table
    function automatic logic [31:0] f_next(input int w, input logic [31:0] q,
                                           input logic [2:0] m, input logic sr,
                                           input logic sl, input logic [31:0] d);
        logic [31:0] mask = (32'h1 << w) - 1;
        logic [31:0] top  = 32'h1 << (w - 1);
        case (m)
            3'd1:    return (q >> 1) | (sr ? top : 32'h0);
            3'd2:    return ((q << 1) | 32'(sl)) & mask;
            3'd3:    return (q >> 1) | ((q & 32'h1) != 0 ? top : 32'h0);
            3'd4:    return ((q << 1) & mask) | ((q & top) != 0 ? 32'h1 : 32'h0);
            3'd5:    return d & mask;
            3'd6:    return (q >> 1) | (q & top);
            3'd7:    return 32'h0;
            default: return q;
        endcase
    endfunction

    // Reference model advances on each rising edge from the sampled inputs
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                mq[i] = 0; mc[i] = 0; md[i] = 0;
            end else if (!en) begin
                md[i] = 0;
            end else begin
                mq[i] = f_next(mw[i], mq[i], mode, sin_r, sin_l, {24'h0, d8});
                if (mode inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6}) begin
                    md[i] = (mc[i] == mw[i] - 1);
                    if (mc[i] < mw[i]) mc[i] = mc[i] + 1;
                end else begin
                    md[i] = 0;
                    if (mode == 3'd5 || mode == 3'd7) mc[i] = 0;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (mon_on) begin
            chk("q4",    32'(q4),    mq[0]);
            chk("cnt4",  32'(cnt4),  32'(mc[0]));
            chk("done4", 32'(done4), 32'(md[0]));
            chk("sr4",   32'(sr4),   mq[0] & 32'h1);
            chk("sl4",   32'(sl4),   (mq[0] >> 3) & 32'h1);
            chk("q8",    32'(q8),    mq[1]);
            chk("cnt8",  32'(cnt8),  32'(mc[1]));
            chk("done8", 32'(done8), 32'(md[1]));
            chk("sr8",   32'(sr8),   mq[1] & 32'h1);
            chk("sl8",   32'(sl8),   (mq[1] >> 7) & 32'h1);
        end
    end

    // Apply one set of inputs across one rising edge, then settle
    task automatic step(input logic rst_n, input logic e, input logic [2:0] m,
                        input logic sr, input logic sl, input logic [7:0] d);
        reset = rst_n; en = e; mode = m; sin_r = sr; sin_l = sl; d8 = d;
        @(posedge clk);
        #1;
    endtask

    int ndone;
    logic [7:0] exp_seq [3];
    logic       exp_sr  [4];
    logic [3:0] exp_q4  [4];

    initial begin
        // Reset wins over a pending load
        step(0, 1, 3'd5, 0, 0, 8'h0F);
        mon_on = 1'b1;
        step(0, 1, 3'd5, 0, 0, 8'h0F);
        chk("rst_q4", 32'(q4), 32'h0);
        chk("rst_cnt4", 32'(cnt4), 32'h0);
        chk("rst_done4", 32'(done4), 32'h0);

        // Serializer: load 1011, shift right four times
        step(1, 1, 3'd5, 0, 0, 8'h0B);
        chk("load_q4", 32'(q4), 32'hB);
        chk("load_cnt4", 32'(cnt4), 32'h0);
        exp_sr = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_q4 = '{4'h5, 4'h2, 4'h1, 4'h0};
        for (int i = 0; i < 4; i++) begin
            chk("ser_sout_r", 32'(sr4), 32'(exp_sr[i]));
            step(1, 1, 3'd1, 0, 0, 8'h0B);
            chk("ser_q4", 32'(q4), 32'(exp_q4[i]));
            chk("ser_cnt4", 32'(cnt4), 32'(i + 1));
            chk("ser_done4", 32'(done4), (i == 3) ? 32'h1 : 32'h0);
        end
        step(1, 1, 3'd1, 0, 0, 8'h0B);
        chk("sat_cnt4", 32'(cnt4), 32'h4);
        chk("sat_done4", 32'(done4), 32'h0);

        // Rotations
        step(1, 1, 3'd5, 0, 0, 8'h0B);
        step(1, 1, 3'd4, 0, 0, 8'h00);
        chk("rol1_q4", 32'(q4), 32'h7);
        step(1, 1, 3'd4, 0, 0, 8'h00);
        chk("rol2_q4", 32'(q4), 32'hE);
        chk("rol2_sl4", 32'(sl4), 32'h1);
        step(1, 1, 3'd3, 0, 0, 8'h00);
        chk("ror_q4", 32'(q4), 32'h7);

        // Arithmetic shift right
        step(1, 1, 3'd5, 0, 0, 8'h08);
        step(1, 1, 3'd6, 0, 0, 8'h00);
        chk("asr1_q4", 32'(q4), 32'hC);
        step(1, 1, 3'd6, 0, 0, 8'h00);
        chk("asr2_q4", 32'(q4), 32'hE);
        step(1, 1, 3'd6, 0, 0, 8'h00);
        chk("asr3_q4", 32'(q4), 32'hF);
        step(1, 1, 3'd5, 0, 0, 8'h04);
        step(1, 1, 3'd6, 1, 0, 8'h00);
        chk("asr4_q4", 32'(q4), 32'h2);

        // 8-bit shift left, enable drop, clear
        step(1, 1, 3'd5, 0, 0, 8'hA5);
        exp_seq = '{8'h4B, 8'h97, 8'h2F};
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 3'd2, 0, 1, 8'h00);
            chk("shl_q8", 32'(q8), 32'(exp_seq[i]));
        end
        step(1, 0, 3'd1, 1, 1, 8'h00);
        step(1, 0, 3'd1, 1, 1, 8'h00);
        chk("hold_q8", 32'(q8), 32'h2F);
        chk("hold_cnt8", 32'(cnt8), 32'h3);
        step(1, 1, 3'd7, 0, 0, 8'h00);
        chk("clr_q8", 32'(q8), 32'h0);
        chk("clr_cnt8", 32'(cnt8), 32'h0);

        // Reset during shifting, then exactly one done over eight shifts
        step(1, 1, 3'd5, 0, 0, 8'hFF);
        for (int i = 0; i < 5; i++) step(1, 1, 3'd1, 0, 0, 8'h00);
        step(0, 1, 3'd1, 1, 1, 8'h00);
        chk("mid_rst_q8", 32'(q8), 32'h0);
        chk("mid_rst_cnt8", 32'(cnt8), 32'h0);
        chk("mid_rst_done8", 32'(done8), 32'h0);
        step(1, 1, 3'd5, 0, 0, 8'h3C);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 3'd1, 0, 0, 8'h00);
            if (done8) ndone++;
        end
        step(1, 1, 3'd1, 0, 0, 8'h00);
        if (done8) ndone++;
        chk("one_done8", 32'(ndone), 32'h1);

        // Randomized traffic, biased toward runs of shift-class modes
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] m;
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel < 14) begin
                case ($urandom_range(0, 4))
                    0: m = 3'd1;
                    1: m = 3'd2;
                    2: m = 3'd3;
                    3: m = 3'd4;
                    default: m = 3'd6;
                endcase
            end else begin
                m = 3'($urandom_range(0, 7));
            end
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0), m,
                 1'($urandom), 1'($urandom), 8'($urandom));
        end

        @(negedge clk);
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
